// File: rtl/mux_n1_pipe_pkg.sv
// Shared constants and helpers for the pipelined N:1 select stage.
// Imported by the combinational mux and the registered top.
package mux_n1_pipe_pkg;

  localparam int MUX_MAX_N = 16;
  localparam int MUX_MAX_W = 64;

  // Ceiling log2 usable in constant expressions; returns 0 for v <= 1.
  function automatic int mux_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n1_comb.sv
// Combinational N:1 W-bit mux with select range check.
// Out-of-range selects return DEFAULT and raise err.
module mux_n1_comb
  import mux_n1_pipe_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          W       = 32,
  parameter int          SW      = 2,
  parameter logic [W-1:0] DEFAULT = '0
) (
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   data,
  output logic           err
);

  localparam int          IW     = mux_clog2(N * W) + 1;
  localparam logic [SW:0] N_CODE = (SW + 1)'(N);

  logic          in_range;
  logic [SW-1:0] sel_idx;
  logic [IW-1:0] base;
  logic [W-1:0]  picked;

  // The range check comes first so an out-of-range code never forms an index.
  always_comb begin
    in_range = ({1'b0, sel} < N_CODE);
    sel_idx  = in_range ? sel : '0;
    base     = IW'(sel_idx) * IW'(W);
    picked   = in_data[base +: W];
    data     = in_range ? picked : DEFAULT;
    err      = ~in_range;
  end

endmodule

// File: rtl/mux_n1_pipe.sv
// Registered N:1 select stage with valid/ready flow control and select lock.
// One output register, no skid buffer: the stage accepts whenever it is empty or draining.
module mux_n1_pipe
  import mux_n1_pipe_pkg::*;
#(
  parameter int           N       = 4,
  parameter int           W       = 32,
  parameter int           SW      = 2,
  parameter logic [W-1:0] DEFAULT = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           sel_lock,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready
);

  if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
    $error("mux_n1_pipe: N=%0d outside 2..%0d", N, MUX_MAX_N);
  end
  if (W < 1 || W > MUX_MAX_W) begin : g_bad_w
    $error("mux_n1_pipe: W=%0d outside 1..%0d", W, MUX_MAX_W);
  end
  if (SW < mux_clog2(N)) begin : g_bad_sw
    $error("mux_n1_pipe: SW=%0d too narrow for N=%0d", SW, N);
  end

  // Handshake: a word moves upstream->stage when in_valid & in_ready at a rising
  // edge, and stage->downstream when out_valid & out_ready at a rising edge.
  // in_ready depends combinationally on out_ready; valid never drops while stalled.

  logic [SW-1:0] sel_q, sel_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic          out_valid_q, out_valid_d;

  logic [SW-1:0] eff_sel;
  logic [W-1:0]  mux_data;
  logic          mux_err;
  logic          accept;

  assign eff_sel = sel_lock ? sel_q : sel;

  mux_n1_comb #(
    .N       (N),
    .W       (W),
    .SW      (SW),
    .DEFAULT (DEFAULT)
  ) u_comb (
    .in_data (in_data),
    .sel     (eff_sel),
    .data    (mux_data),
    .err     (mux_err)
  );

  always_comb begin
    in_ready    = ~out_valid_q | out_ready;
    accept      = in_valid & in_ready;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      // When locked eff_sel already equals sel_q, so sel_q holds.
      sel_d       = eff_sel;
      out_data_d  = mux_data;
      out_err_d   = mux_err;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

  a_stall_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_err))
  );

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Self-checking bench for mux_n1_pipe: directed cases plus a randomized run
// scored against a queue-based model of the single-register stage.
module tb_mux_n1_pipe;

  localparam int           N   = 4;
  localparam int           W   = 8;
  localparam int           SW  = 3;
  localparam logic [W-1:0] DEF = 8'hEE;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           sel_lock;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;

  always #5 clk = ~clk;

  mux_n1_pipe #(
    .N       (N),
    .W       (W),
    .SW      (SW),
    .DEFAULT (DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .sel_lock  (sel_lock),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           n_obs = 0;
  int           m_sel_q = 0;
  logic [W:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {err, data} for a given effective select, straight from the channel layout.
  function automatic logic [W:0] ref_word(input logic [N*W-1:0] d, input int s);
    if (s >= N) return {1'b1, DEF};
    return {1'b0, W'(d >> (s * W))};
  endfunction

  // One clock cycle: drive at negedge, check and advance the model before the posedge,
  // and return 1 time unit after the posedge.
  task automatic cycle(input logic iv, input int s, input logic lk, input logic ord,
                       input logic [N*W-1:0] d);
    logic exp_rdy;
    int   eff;
    @(negedge clk);
    in_valid  = iv;
    sel       = SW'(s);
    sel_lock  = lk;
    out_ready = ord;
    in_data   = d;
    #1;
    exp_rdy = (exp_q.size() == 0) || ord;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_word", {out_err, out_data}, exp_q[0]);
    if (out_valid && ord) n_obs++;
    if (exp_q.size() != 0 && ord) void'(exp_q.pop_front());
    if (iv && exp_rdy) begin
      eff = lk ? m_sel_q : s;
      exp_q.push_back(ref_word(d, eff));
      m_sel_q = eff;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sel_q = 0;
  endtask

  localparam logic [N*W-1:0] D1 = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    int n0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = '0;
    sel_lock  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_err", out_err, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    cycle(1'b1, 2, 1'b0, 1'b1, D1);
    check("sel2_data", out_data, 8'h33);
    check("sel2_err", out_err, 1'b0);
    check("sel2_valid", out_valid, 1'b1);
    cycle(1'b1, 5, 1'b0, 1'b1, D1);
    check("oor_data", out_data, 8'hEE);
    check("oor_err", out_err, 1'b1);
    cycle(1'b1, 0, 1'b0, 1'b1, D1);
    check("sel0_data", out_data, 8'h11);
    check("sel0_err", out_err, 1'b0);

    cycle(1'b1, 1, 1'b0, 1'b1, D1);
    check("sel1_data", out_data, 8'h22);
    cycle(1'b1, 3, 1'b1, 1'b1, {8'h44, 8'h33, 8'h99, 8'h11});
    check("lock_data", out_data, 8'h99);
    cycle(1'b1, 0, 1'b1, 1'b1, {8'h44, 8'h33, 8'h77, 8'h11});
    check("lock_hold", out_data, 8'h77);

    // Back-pressure then a 20-word stream at full rate.
    cycle(1'b1, 2, 1'b0, 1'b1, D1);
    repeat (3) begin
      cycle(1'b1, $urandom_range(0, 3), 1'b0, 1'b0, $urandom);
      check("bp_hold", out_data, 8'h33);
      check("bp_valid", out_valid, 1'b1);
    end
    n0 = n_obs;
    repeat (20) cycle(1'b1, $urandom_range(0, 3), 1'b0, 1'b1, $urandom);
    cycle(1'b0, 0, 1'b0, 1'b1, '0);
    check("stream_count", n_obs - n0, 21);
    check("stream_empty", out_valid, 1'b0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 3, 1'b0, 1'b1, D1);
    cycle(1'b0, 0, 1'b0, 1'b0, D1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 8'h00);
    check("arst_err", out_err, 1'b0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 7, 1'b1, 1'b1, D1);
    check("rst_selq_lock", out_data, 8'h11);
    cycle(1'b1, 3, 1'b0, 1'b1, D1);
    check("post_rst_data", out_data, 8'h44);

    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 6), {$urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
